// File: rtl/cpu_regs_pkg.sv
// Shared register-file definitions for the CPU pipeline: register count, index type
// and the hard-wired zero register (XZR), which never carries a hazard.
package cpu_regs_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 5'd31;

  function automatic logic is_tracked(input reg_idx_t idx);
    return idx != ZERO_REG;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-issue / writeback-retire bundle between the pipeline (master) and the
// register scoreboard (slave).
interface reg_scoreboard_if;
  import cpu_regs_pkg::*;

  logic                flush;
  logic                issue_valid;
  logic                issue_rn_used;
  logic                issue_rm_used;
  logic                issue_rd_wr;
  reg_idx_t            issue_rn;
  reg_idx_t            issue_rm;
  reg_idx_t            issue_rd;
  logic                wb_valid;
  reg_idx_t            wb_rd;
  logic                stall;
  logic [NUM_REGS-1:0] pending;
  logic                err_underflow;

  modport master (
    output flush, issue_valid, issue_rn_used, issue_rm_used, issue_rd_wr,
           issue_rn, issue_rm, issue_rd, wb_valid, wb_rd,
    input  stall, pending, err_underflow
  );

  modport slave (
    input  flush, issue_valid, issue_rn_used, issue_rm_used, issue_rd_wr,
           issue_rn, issue_rm, issue_rd, wb_valid, wb_rd,
    output stall, pending, err_underflow
  );

endinterface

// File: rtl/scoreboard_entry.sv
// Outstanding-write counter for one architectural register. Saturates at both ends;
// the parent guarantees inc is never requested at max and dec never at zero.
module scoreboard_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_nonzero,
  output logic             o_at_max,
  output logic             o_is_one
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;

  // Simultaneous inc and dec cancel, which keeps a full counter legal when the
  // same register issues and retires together.
  always_ff @(posedge clk) begin
    if (!reset_n || i_clr) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_nonzero = |r_count;
  assign o_at_max  = &r_count;
  assign o_is_one  = (r_count == CNT_W'(1));

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: stalls decode on RAW hazards or a saturated destination counter,
// records issued destinations and retires them at writeback.
module reg_scoreboard
  import cpu_regs_pkg::*;
#(
  parameter int CNT_W     = 2,
  parameter int BYPASS_WB = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  reg_scoreboard_if.slave bus
);

  logic [CNT_W-1:0]    w_count [NUM_REGS];
  logic [NUM_REGS-1:0] w_nonzero;
  logic [NUM_REGS-1:0] w_at_max;
  logic [NUM_REGS-1:0] w_is_one;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic                w_rn_hz;
  logic                w_rm_hz;
  logic                w_rd_full;
  logic                w_stall;
  logic                w_issue_fire;
  logic                w_retire;
  logic                w_underflow;
  logic                r_err_underflow;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    scoreboard_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_inc     (w_inc[g]),
      .i_dec     (w_dec[g]),
      .i_clr     (bus.flush),
      .o_count   (w_count[g]),
      .o_nonzero (w_nonzero[g]),
      .o_at_max  (w_at_max[g]),
      .o_is_one  (w_is_one[g])
    );
  end

  // Hazards use pre-issue counts, so an instruction never waits on its own destination.
  always_comb begin
    w_rn_hz = bus.issue_rn_used && is_tracked(bus.issue_rn) && w_nonzero[bus.issue_rn]
              && !((BYPASS_WB != 0) && bus.wb_valid && (bus.wb_rd == bus.issue_rn)
                   && w_is_one[bus.issue_rn]);
    w_rm_hz = bus.issue_rm_used && is_tracked(bus.issue_rm) && w_nonzero[bus.issue_rm]
              && !((BYPASS_WB != 0) && bus.wb_valid && (bus.wb_rd == bus.issue_rm)
                   && w_is_one[bus.issue_rm]);
    w_rd_full = bus.issue_rd_wr && is_tracked(bus.issue_rd) && w_at_max[bus.issue_rd]
                && !(bus.wb_valid && (bus.wb_rd == bus.issue_rd));
    w_stall      = bus.issue_valid && (w_rn_hz || w_rm_hz || w_rd_full);
    w_issue_fire = bus.issue_valid && !w_stall && bus.issue_rd_wr && is_tracked(bus.issue_rd);
    w_retire     = bus.wb_valid && is_tracked(bus.wb_rd);
    w_underflow  = w_retire && (w_count[bus.wb_rd] == '0) && !bus.flush;
    w_inc        = '0;
    w_dec        = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_inc[i] = w_issue_fire && (bus.issue_rd == reg_idx_t'(i));
      w_dec[i] = w_retire && w_nonzero[i] && (bus.wb_rd == reg_idx_t'(i));
    end
  end

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err_underflow <= 1'b0;
    end else if (w_underflow) begin
      r_err_underflow <= 1'b1;
    end
  end

  assign bus.stall         = w_stall;
  assign bus.pending       = w_nonzero;
  assign bus.err_underflow = r_err_underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: two DUTs (writeback bypass on/off) share directed stimulus;
// expectations are queued per cycle and a negedge monitor pops and compares them.
module tb_reg_scoreboard;
  import cpu_regs_pkg::*;

  typedef struct {
    string       name;
    int          cyc;
    logic        stA;
    logic        stB;
    logic [31:0] pend;
    logic        err;
  } exp_t;

  logic     clk = 1'b0;
  logic     rstN;
  logic     fl, iv, rnU, rmU, rdW, wbV;
  reg_idx_t rn, rm, rd, wb;

  int   cycle      = 0;
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  exp_t expQ[$];

  reg_scoreboard_if ifA ();
  reg_scoreboard_if ifB ();

  assign ifA.flush = fl, ifA.issue_valid = iv, ifA.issue_rn_used = rnU, ifA.issue_rm_used = rmU,
         ifA.issue_rd_wr = rdW, ifA.issue_rn = rn, ifA.issue_rm = rm, ifA.issue_rd = rd,
         ifA.wb_valid = wbV, ifA.wb_rd = wb;
  assign ifB.flush = fl, ifB.issue_valid = iv, ifB.issue_rn_used = rnU, ifB.issue_rm_used = rmU,
         ifB.issue_rd_wr = rdW, ifB.issue_rn = rn, ifB.issue_rm = rm, ifB.issue_rd = rd,
         ifB.wb_valid = wbV, ifB.wb_rd = wb;

  reg_scoreboard #(.CNT_W(2), .BYPASS_WB(1)) dutA (.clk(clk), .reset_n(rstN), .bus(ifA));
  reg_scoreboard #(.CNT_W(2), .BYPASS_WB(0)) dutB (.clk(clk), .reset_n(rstN), .bus(ifB));

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic clearInputs();
    rstN = 1'b1; fl = 1'b0; iv = 1'b0; rnU = 1'b0; rmU = 1'b0; rdW = 1'b0; wbV = 1'b0;
    rn = '0; rm = '0; rd = '0; wb = '0;
  endtask

  task automatic setIssue(input logic rnUsed, input reg_idx_t rnIdx, input logic rmUsed,
                          input reg_idx_t rmIdx, input logic rdWr, input reg_idx_t rdIdx);
    iv = 1'b1; rnU = rnUsed; rn = rnIdx; rmU = rmUsed; rm = rmIdx; rdW = rdWr; rd = rdIdx;
  endtask

  task automatic setWb(input reg_idx_t idx);
    wbV = 1'b1; wb = idx;
  endtask

  // Inputs for this cycle are already driven; queue what both DUTs must show, then advance.
  task automatic applyStimulus(input string name, input logic stA, input logic stB,
                               input logic [31:0] pend, input logic err);
    exp_t e;
    e.name = name; e.cyc = cycle; e.stA = stA; e.stB = stB; e.pend = pend; e.err = err;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic compareVal(input string vec, input string what,
                            input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      failCount++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", vec, what, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareVal(e.name, "stallA",   {31'b0, ifA.stall},         {31'b0, e.stA});
    compareVal(e.name, "stallB",   {31'b0, ifB.stall},         {31'b0, e.stB});
    compareVal(e.name, "pendingA", ifA.pending,                e.pend);
    compareVal(e.name, "pendingB", ifB.pending,                e.pend);
    compareVal(e.name, "errA",     {31'b0, ifA.err_underflow}, {31'b0, e.err});
    compareVal(e.name, "errB",     {31'b0, ifB.err_underflow}, {31'b0, e.err});
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (expQ.size() != 0 && expQ[0].cyc <= cycle) begin
      e = expQ.pop_front();
      if (e.cyc < cycle) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL %s stale: checked at cycle %0d, required cycle %0d", e.name, cycle, e.cyc);
      end else begin
        checkOutput(e);
      end
    end
  end

  initial begin
    clearInputs();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;

    // Reset mid-operation
    setIssue(0, 0, 0, 0, 1, 3);    applyStimulus("rst_issue3",  0, 0, 32'h0,    0);
    setIssue(0, 0, 0, 0, 1, 7);    applyStimulus("rst_issue7",  0, 0, 32'h8,    0);
    rstN = 1'b0;                   applyStimulus("rst_assert",  0, 0, 32'h88,   0);
    setIssue(1, 3, 0, 0, 0, 0);    applyStimulus("rst_read3",   0, 0, 32'h0,    0);

    // RAW stall and writeback bypass
    setIssue(0, 0, 0, 0, 1, 5);    applyStimulus("raw_issue5",  0, 0, 32'h0,    0);
    setIssue(1, 5, 0, 0, 0, 0);    applyStimulus("raw_read5",   1, 1, 32'h20,   0);
    setIssue(1, 5, 0, 0, 0, 0);
    setWb(5);                      applyStimulus("raw_bypass5", 0, 1, 32'h20,   0);
    setIssue(1, 5, 0, 0, 0, 0);    applyStimulus("raw_after5",  0, 0, 32'h0,    0);
    setIssue(1, 5, 0, 0, 1, 10);   applyStimulus("raw_issue10", 0, 0, 32'h0,    0);
    setIssue(0, 0, 1, 10, 1, 10);  applyStimulus("raw_rm10",    1, 1, 32'h400,  0);
    setWb(10);                     applyStimulus("raw_wb10",    0, 0, 32'h400,  0);
    setIssue(1, 11, 0, 0, 1, 11);  applyStimulus("self_rn11",   0, 0, 32'h0,    0);
    setWb(11);                     applyStimulus("self_wb11",   0, 0, 32'h800,  0);

    // XZR is never tracked
    setIssue(0, 0, 0, 0, 1, 31);   applyStimulus("xzr_issue",   0, 0, 32'h0,    0);
    setIssue(1, 31, 1, 31, 0, 0);  applyStimulus("xzr_read",    0, 0, 32'h0,    0);
    setWb(31);                     applyStimulus("xzr_wb",      0, 0, 32'h0,    0);
    applyStimulus("xzr_idle", 0, 0, 32'h0, 0);

    // WAW saturation at count 3
    setIssue(0, 0, 0, 0, 1, 9);    applyStimulus("waw_1",       0, 0, 32'h0,    0);
    setIssue(0, 0, 0, 0, 1, 9);    applyStimulus("waw_2",       0, 0, 32'h200,  0);
    setIssue(0, 0, 0, 0, 1, 9);    applyStimulus("waw_3",       0, 0, 32'h200,  0);
    setIssue(0, 0, 0, 0, 1, 9);    applyStimulus("waw_full",    1, 1, 32'h200,  0);
    setIssue(0, 0, 0, 0, 1, 9);
    setWb(9);                      applyStimulus("waw_net0",    0, 0, 32'h200,  0);
    setWb(9);                      applyStimulus("waw_ret3",    0, 0, 32'h200,  0);
    setIssue(1, 9, 0, 0, 0, 0);
    setWb(9);                      applyStimulus("waw_ret2",    1, 1, 32'h200,  0);
    setIssue(1, 9, 0, 0, 0, 0);
    setWb(9);                      applyStimulus("waw_ret1",    0, 1, 32'h200,  0);
    applyStimulus("waw_empty", 0, 0, 32'h0, 0);

    // Flush squashes records and ignores same-cycle issue/retire
    setIssue(0, 0, 0, 0, 1, 1);    applyStimulus("fl_issue1",   0, 0, 32'h0,    0);
    setIssue(0, 0, 0, 0, 1, 2);    applyStimulus("fl_issue2",   0, 0, 32'h2,    0);
    setIssue(0, 0, 0, 0, 1, 4);    applyStimulus("fl_issue4",   0, 0, 32'h6,    0);
    fl = 1'b1;
    setIssue(0, 0, 0, 0, 1, 6);
    setWb(1);                      applyStimulus("fl_assert",   0, 0, 32'h16,   0);
    applyStimulus("fl_after", 0, 0, 32'h0, 0);
    setIssue(1, 6, 0, 0, 0, 0);    applyStimulus("fl_read6",    0, 0, 32'h0,    0);

    // Underflow is sticky through flush, cleared by reset
    setWb(12);                     applyStimulus("uf_wb12",     0, 0, 32'h0,    0);
    applyStimulus("uf_set", 0, 0, 32'h0, 1);
    fl = 1'b1;                     applyStimulus("uf_flush",    0, 0, 32'h0,    1);
    applyStimulus("uf_kept", 0, 0, 32'h0, 1);
    rstN = 1'b0;                   applyStimulus("uf_reset",    0, 0, 32'h0,    1);
    applyStimulus("uf_clear", 0, 0, 32'h0, 0);

    // Issue and retire of different registers in one cycle
    setIssue(0, 0, 0, 0, 1, 13);   applyStimulus("mix_issue13", 0, 0, 32'h0,    0);
    setIssue(0, 0, 0, 0, 1, 14);
    setWb(13);                     applyStimulus("mix_both",    0, 0, 32'h2000, 0);
    applyStimulus("mix_after", 0, 0, 32'h4000, 0);

    for (int k = 0; k < 5 && expQ.size() != 0; k++) @(negedge clk);
    if (expQ.size() != 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
